// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: op codes, controller states and op
// classification helpers. Build option SEQ_ALU_DIVIDE_EN adds the divide
// state and makes divu/remu multi-cycle.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHRA  = 4'd7;
  localparam logic [3:0] OP_LTU   = 4'd8;
  localparam logic [3:0] OP_GTU   = 4'd9;
  localparam logic [3:0] OP_LTS   = 4'd10;
  localparam logic [3:0] OP_GTS   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_MULHU = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

`ifdef SEQ_ALU_DIVIDE_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
`else
  typedef enum logic [1:0] {IDLE, MUL} state_e;
`endif

  // Ops that go through the iterative multiply/divide unit.
  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef SEQ_ALU_DIVIDE_EN
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL) || (op == OP_MULHU);
`endif
  endfunction

  // mulhu takes the high product half; remu takes the remainder, which
  // the divider leaves in the high half of the shared shift register.
  function automatic logic selects_high(input logic [3:0] op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide unit for seq_alu. One shared 2*WIDTH shift
// register and one adder/subtractor, retiring one bit per clock over WIDTH
// iterations. The divider portion exists only with SEQ_ALU_DIVIDE_EN.
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef SEQ_ALU_DIVIDE_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;

  assign hi   = acc_q[2*WIDTH-1:WIDTH];
  assign lo   = acc_q[WIDTH-1:0];
  assign done = busy_q && (cnt_q == '0);

`ifdef SEQ_ALU_DIVIDE_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;

  // Shared adder: hi + multiplicand, or trial remainder - divisor.
  always_comb begin
    add_a     = is_div_q ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    add_b     = is_div_q ? ~{1'b0, opb_q} : {1'b0, opb_q};
    sum       = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(is_div_q);
    no_borrow = sum[WIDTH+1];
  end
`else
  logic [WIDTH:0] sum;

  // Shared adder: hi + multiplicand.
  always_comb begin
    sum = {1'b0, hi} + {1'b0, opb_q};
  end
`endif

  // Next-state: load on start, iterate while the counter is non-zero,
  // then hold the finished value until the controller takes it.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opb_d  = opb_q;
`ifdef SEQ_ALU_DIVIDE_EN
    is_div_d = is_div_q;
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(WIDTH);
      acc_d  = {{WIDTH{1'b0}}, a};
      opb_d  = b;
`ifdef SEQ_ALU_DIVIDE_EN
      is_div_d = is_div;
`endif
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
`ifdef SEQ_ALU_DIVIDE_EN
        if (is_div_q) begin
          // Restoring step: keep the difference only when it did not borrow.
          // A zero divisor never borrows, giving all-ones and rem = operand1.
          acc_d = {no_borrow ? sum[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]},
                   lo[WIDTH-2:0], no_borrow};
        end else
`endif
        begin
          // Shift-add step: conditionally add, then shift right one place.
          acc_d = lo[0] ? {sum[WIDTH:0], lo[WIDTH-1:1]}
                        : {1'b0, hi, lo[WIDTH-1:1]};
        end
      end else if (ack) begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opb_q  <= '0;
`ifdef SEQ_ALU_DIVIDE_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opb_q  <= opb_d;
`ifdef SEQ_ALU_DIVIDE_EN
      is_div_q <= is_div_d;
`endif
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake. Single-cycle ops compute
// combinationally and land in the result register one clock after accept;
// mul/mulhu (and divu/remu when SEQ_ALU_DIVIDE_EN is defined) run through
// seq_alu_muldiv for WIDTH+1 clocks while issue is stalled.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  import alu_pkg::*;

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             sel_hi_q, sel_hi_d;

  logic             out_free;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  logic             md_start;
  logic             md_ack;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_res;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && out_free;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

  assign add_sum = {1'b0, operand1} + {1'b0, operand2};
  assign sub_sum = {1'b0, operand1} + {1'b0, ~operand2} + (WIDTH+1)'(1);
  assign shamt   = operand2[SHAMT_W-1:0];
  assign md_res  = sel_hi_q ? md_hi : md_lo;

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
`ifdef SEQ_ALU_DIVIDE_EN
    .is_div  ((operation == OP_DIVU) || (operation == OP_REMU)),
`endif
    .a       (operand1),
    .b       (operand2),
    .ack     (md_ack),
    .done    (md_done),
    .hi      (md_hi),
    .lo      (md_lo)
  );

  // Single-cycle datapath on the live inputs; only used at accept.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (operation)
      OP_ADD:  {alu_carry, alu_res} = add_sum;
      OP_SUB:  {alu_carry, alu_res} = sub_sum;
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_SHL:  alu_res = operand1 << shamt;
      OP_SHR:  alu_res = operand1 >> shamt;
      OP_SHRA: alu_res = $signed(operand1) >>> shamt;
      OP_LTU:  alu_res = {{(WIDTH-1){1'b0}}, operand1 < operand2};
      OP_GTU:  alu_res = {{(WIDTH-1){1'b0}}, operand1 > operand2};
      OP_LTS:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      OP_GTS:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand1) > $signed(operand2)};
      // Multi-cycle ops never take this path; without the divider,
      // divu/remu retire here as a zero result.
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_res = '0;
    endcase
  end

  // Controller: accept, launch iterative ops, write the result register.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    sel_hi_d    = sel_hi_q;
    md_start    = 1'b0;
    md_ack      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (is_multicycle(operation)) begin
            md_start = 1'b1;
            sel_hi_d = selects_high(operation);
`ifdef SEQ_ALU_DIVIDE_EN
            state_d  = ((operation == OP_DIVU) || (operation == OP_REMU)) ? DIV : MUL;
`else
            state_d  = MUL;
`endif
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_carry;
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        // Completion retries every clock until the output slot is free.
        if (md_done && out_free) begin
          md_ack      = 1'b1;
          result_d    = md_res;
          zero_d      = (md_res == '0);
          carry_d     = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // Controller and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      sel_hi_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      sel_hi_q    <= sel_hi_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32. Divide vectors
// follow SEQ_ALU_DIVIDE_EN: iterative results when defined, single-cycle
// zero results otherwise.
module tb_seq_alu;

  localparam logic [3:0] T_ADD = 4'd0,  T_SUB = 4'd1,  T_AND = 4'd2,  T_OR = 4'd3;
  localparam logic [3:0] T_XOR = 4'd4,  T_SHL = 4'd5,  T_SHR = 4'd6,  T_SHRA = 4'd7;
  localparam logic [3:0] T_LTU = 4'd8,  T_GTU = 4'd9,  T_LTS = 4'd10, T_GTS = 4'd11;
  localparam logic [3:0] T_MUL = 4'd12, T_MULHU = 4'd13, T_DIVU = 4'd14, T_REMU = 4'd15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        carry;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle op; in_valid is left high so calls chain back-to-back.
  task automatic sc_step(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_c);
    operation = op;
    operand1  = a;
    operand2  = b;
    in_valid  = 1'b1;
    #1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
    check({tag, "_carry"}, {31'd0, carry}, {31'd0, exp_c});
  endtask

  // One iterative op from idle: checks latency, stall and the final value.
  task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res);
    int   lat;
    logic ir_bad;
    operation = op;
    operand1  = a;
    operand2  = b;
    in_valid  = 1'b1;
    #1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    // Scramble the inputs: the captured operands must be used.
    in_valid  = 1'b0;
    operation = T_ADD;
    operand1  = ~a;
    operand2  = 32'h0;
    lat    = 0;
    ir_bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) ir_bad = 1'b1;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd33);
    check({tag, "_stall"}, {31'd0, ir_bad}, 32'd0);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
    check({tag, "_carry"}, {31'd0, carry}, 32'd0);
    tick();
    check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic bad;

    // Reset state.
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operation = 4'd0;
    operand1  = 32'd0;
    operand2  = 32'd0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;
    tick();

    // Add wrap: result valid one clock after accept.
    check("pre_add_valid", {31'd0, out_valid}, 32'd0);
    sc_step("add_wrap", T_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);

    // Back-to-back single-cycle ops at one per clock.
    sc_step("shra", T_SHRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    sc_step("shr", T_SHR, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    sc_step("shr_hi_ign", T_SHR, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0);
    sc_step("shra_pos", T_SHRA, 32'h7000_0000, 32'd4, 32'h0700_0000, 1'b0);
    sc_step("shl_hi_ign", T_SHL, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0);
    sc_step("and", T_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    sc_step("or", T_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    sc_step("xor", T_XOR, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b0);
    sc_step("sub_nb", T_SUB, 32'd5, 32'd3, 32'd2, 1'b1);
    sc_step("sub_borrow", T_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    sc_step("sub_eq", T_SUB, 32'd9, 32'd9, 32'd0, 1'b1);
    sc_step("ltu", T_LTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    sc_step("gtu", T_GTU, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    sc_step("lts", T_LTS, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    sc_step("gts", T_GTS, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
`ifndef SEQ_ALU_DIVIDE_EN
    sc_step("divu_off", T_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
    sc_step("remu_off", T_REMU, 32'd100, 32'd7, 32'd0, 1'b0);
`endif
    in_valid = 1'b0;
    tick();
    check("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Iterative multiply.
    run_multi("mul_2p32", T_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0);
    run_multi("mulhu_2p32", T_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1);
    run_multi("mul_max", T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_multi("mulhu_max", T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

`ifdef SEQ_ALU_DIVIDE_EN
    // Iterative divide, including divide by zero.
    run_multi("divu", T_DIVU, 32'd100, 32'd7, 32'd14);
    run_multi("remu", T_REMU, 32'd100, 32'd7, 32'd2);
    run_multi("divu_z", T_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_multi("remu_z", T_REMU, 32'd5, 32'd0, 32'd5);
    run_multi("divu_big", T_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF);
`endif

    // Backpressure: held result stays stable and blocks issue.
    out_ready = 1'b0;
    operation = T_ADD;
    operand1  = 32'd2;
    operand2  = 32'd3;
    in_valid  = 1'b1;
    tick();
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    operand1 = 32'd1;
    operand2 = 32'd1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || result !== 32'd5 || in_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    check("bp_hold", {31'd0, bad}, 32'd0);
    check("bp_result", result, 32'd5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_one_xfer", {31'd0, out_valid}, 32'd0);
    tick();
    check("bp_no_second", {31'd0, out_valid}, 32'd0);

    // Reset during a multiply aborts it.
    operation = T_MUL;
    operand1  = 32'd3;
    operand2  = 32'd5;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    sc_step("post_abort_add", T_ADD, 32'd7, 32'd8, 32'd15, 1'b0);
    in_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    check("abort_no_result", {31'd0, bad}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
